// File: rtl/sec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sec_pkg                                                              |
// | Seven-segment patterns, deconverter FSM states and seconds helpers.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sec_pkg;

    // Active-low patterns, written MSB first: bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [5:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HAVE_ONES = 2'd1,
        ST_HAVE_TENS = 2'd2
    } sec_state_t;

    // Seven bits wide so an out-of-range tens digit stays visible above SEC_MAX
    function automatic logic [6:0] bcd_to_sec(input logic [3:0] tens,
                                              input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_to_bcd                                                          |
// | Combinational active-low seven-segment to BCD digit decoder.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_to_bcd
    import sec_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sec_deconv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sec_deconv                                                           |
// | Rebuilds a 0..59 seconds value from strobed two-digit 7-seg frames.  |
// | Option: SEC_DECONV_DEGLITCH_EN (accept a digit only on repeat).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sec_deconv
    import sec_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       seg_stb,
    input  logic       dig_sel,
    output logic [5:0] sec_val,
    output logic       sec_vld,
    output logic       err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sec_state_t       r_state, w_state_next;
    logic [3:0]       r_ones, w_ones_next;
    logic [3:0]       r_tens, w_tens_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [5:0]       r_sec_val, w_val_next;
    logic             r_sec_vld, w_vld_next;
    logic             r_err, w_err_next;

    logic [3:0]       w_digit;
    logic             w_valid;
    logic             w_accept;
    logic             w_bad;
    logic             w_same;
    logic             w_timeout;
    logic [3:0]       w_frame_tens;
    logic [3:0]       w_frame_ones;
    logic [6:0]       w_sum;

    seg7_to_bcd u_dec (
        .seg   (seg),
        .digit (w_digit),
        .valid (w_valid)
    );

    assign w_bad     = seg_stb && !w_valid;
    assign w_same    = ((r_state == ST_HAVE_TENS) == dig_sel);
    assign w_timeout = (r_state != ST_IDLE) && !seg_stb
                       && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Only meaningful when the strobe completes a frame with the other digit
    assign w_frame_tens = dig_sel ? w_digit : r_tens;
    assign w_frame_ones = dig_sel ? r_ones  : w_digit;
    assign w_sum        = bcd_to_sec(w_frame_tens, w_frame_ones);

`ifdef SEC_DECONV_DEGLITCH_EN
    logic       r_pend_vld, w_pend_vld_next;
    logic       r_pend_sel, w_pend_sel_next;
    logic [6:0] r_pend_seg, w_pend_seg_next;

    assign w_accept = seg_stb && w_valid && r_pend_vld
                      && (r_pend_sel == dig_sel) && (r_pend_seg == seg);

    // A strobe that is not a confirmed repeat becomes the new candidate
    always_comb begin
        w_pend_vld_next = r_pend_vld;
        w_pend_sel_next = r_pend_sel;
        w_pend_seg_next = r_pend_seg;
        if (w_bad || w_timeout || w_accept) begin
            w_pend_vld_next = 1'b0;
        end else if (seg_stb) begin
            w_pend_vld_next = 1'b1;
            w_pend_sel_next = dig_sel;
            w_pend_seg_next = seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend_sel <= 1'b0;
            r_pend_seg <= 7'd0;
        end else begin
            r_pend_vld <= w_pend_vld_next;
            r_pend_sel <= w_pend_sel_next;
            r_pend_seg <= w_pend_seg_next;
        end
    end
`else
    assign w_accept = seg_stb && w_valid;
`endif

    always_comb begin
        w_state_next = r_state;
        w_ones_next  = r_ones;
        w_tens_next  = r_tens;
        w_cnt_next   = r_cnt;
        w_val_next   = r_sec_val;
        w_vld_next   = 1'b0;
        w_err_next   = 1'b0;

        if (w_bad) begin
            w_err_next   = 1'b1;
            w_ones_next  = 4'd0;
            w_tens_next  = 4'd0;
            w_cnt_next   = '0;
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_cnt_next = '0;
                        if (dig_sel) begin
                            w_tens_next  = w_digit;
                            w_state_next = ST_HAVE_TENS;
                        end else begin
                            w_ones_next  = w_digit;
                            w_state_next = ST_HAVE_ONES;
                        end
                    end
                end
                ST_HAVE_ONES, ST_HAVE_TENS: begin
                    if (w_accept && w_same) begin
                        if (dig_sel) w_tens_next = w_digit;
                        else         w_ones_next = w_digit;
                        w_cnt_next = '0;
                    end else if (w_accept) begin
                        if (w_sum > {1'b0, SEC_MAX}) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_vld_next = 1'b1;
                            w_val_next = w_sum[5:0];
                        end
                        w_ones_next  = 4'd0;
                        w_tens_next  = 4'd0;
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end else if (seg_stb) begin
                        w_cnt_next = '0;
                    end else if (w_timeout) begin
                        w_err_next   = 1'b1;
                        w_ones_next  = 4'd0;
                        w_tens_next  = 4'd0;
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_cnt     <= '0;
            r_sec_val <= 6'd0;
            r_sec_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ones    <= w_ones_next;
            r_tens    <= w_tens_next;
            r_cnt     <= w_cnt_next;
            r_sec_val <= w_val_next;
            r_sec_vld <= w_vld_next;
            r_err     <= w_err_next;
        end
    end

    assign sec_val = r_sec_val;
    assign sec_vld = r_sec_vld;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sec_deconv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sec_deconv                                                        |
// | Scoreboard bench: directed frames, expected events queued by cycle.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sec_deconv;

    localparam int TO     = 16;
    localparam int K_NONE = 0;
    localparam int K_VLD  = 1;
    localparam int K_ERR  = 2;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'd0;
    logic       seg_stb = 1'b0;
    logic       dig_sel = 1'b0;
    logic [5:0] sec_val;
    logic       sec_vld;
    logic       err;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_cyc = 0;
    bit   final_chk = 1'b0;
    bit   final_done = 1'b0;

    sec_deconv #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .seg_stb (seg_stb),
        .dig_sel (dig_sel),
        .sec_val (sec_val),
        .sec_vld (sec_vld),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_valid(input logic [6:0] p);
        return (p == P0) || (p == P1) || (p == P2) || (p == P3) || (p == P4) ||
               (p == P5) || (p == P6) || (p == P7) || (p == P8) || (p == P9);
    endfunction

    // Monitor: reset state while rst is high, otherwise pop on every output event
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            total++;
            if (sec_val != 6'd0 || sec_vld || err) begin
                bad++;
                $display("FAIL reset_state: got val=%0d vld=%0b err=%0b, need 0/0/0",
                         sec_val, sec_vld, err);
            end
        end else begin
            if (sec_vld && err) begin
                total++;
                bad++;
                $display("FAIL vld_err_overlap: both high at cyc=%0d", cyc);
            end
            if (sec_vld || err) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got vld=%0b err=%0b val=%0d cyc=%0d, need no event",
                             sec_vld, err, sec_val, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.kind != (sec_vld ? K_VLD : K_ERR) || e.cyc != cyc ||
                        e.val != int'(sec_val)) begin
                        bad++;
                        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, need kind=%0d val=%0d cyc=%0d",
                                 sec_vld ? K_VLD : K_ERR, sec_val, cyc, e.kind, e.val, e.cyc);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                total++;
                bad++;
                e = q.pop_front();
                $display("FAIL missing_event: got none at cyc=%0d, need kind=%0d val=%0d cyc=%0d",
                         cyc, e.kind, e.val, e.cyc);
            end
            if (final_chk && !final_done) begin
                final_done = 1'b1;
                total++;
                if (q.size() != 0) begin
                    bad++;
                    $display("FAIL drain: got %0d pending events, need 0", q.size());
                end
            end
        end
    end

    // Called just after a negedge; the strobe is sampled on the next posedge
    task automatic pulse(input logic sel, input logic [6:0] pat,
                         input int kind, input int val);
        if (kind != K_NONE) q.push_back('{kind: kind, val: val, cyc: cyc + 1});
        last_cyc = cyc + 1;
        seg      = pat;
        dig_sel  = sel;
        seg_stb  = 1'b1;
        @(negedge clk);
        seg_stb  = 1'b0;
        seg      = 7'($urandom);
        dig_sel  = 1'($urandom);
    endtask

    task automatic send(input logic sel, input logic [6:0] pat,
                        input int kind, input int val);
`ifdef SEC_DECONV_DEGLITCH_EN
        if (is_valid(pat)) pulse(sel, pat, K_NONE, 0);
`endif
        pulse(sel, pat, kind, val);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            seg     = 7'($urandom);
            dig_sel = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic expect_timeout(input int val);
        q.push_back('{kind: K_ERR, val: val, cyc: last_cyc + TO});
    endtask

    task automatic drain();
        for (int i = 0; i < TO + 40 && q.size() != 0; i++) @(negedge clk);
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        send(1'b1, P2, K_NONE, 0);          // tens 2, ones 4 -> 24
        send(1'b0, P4, K_VLD, 24);
        drain();
        send(1'b0, P9, K_NONE, 0);          // reverse order -> 59
        send(1'b1, P5, K_VLD, 59);
        drain();
        send(1'b1, P6, K_NONE, 0);          // tens 6 -> out of range
        send(1'b0, P0, K_ERR, 59);
        drain();
        send(1'b0, 7'b1111111, K_ERR, 59);  // blank pattern
        drain();
        send(1'b1, P1, K_NONE, 0);          // invalid mid-frame clears tens
        send(1'b0, 7'b0000001, K_ERR, 59);
        send(1'b0, P5, K_NONE, 0);
        expect_timeout(59);
        drain();
        send(1'b0, P3, K_NONE, 0);          // ones overwritten 3 -> 7
        send(1'b0, P7, K_NONE, 0);
        send(1'b1, P1, K_VLD, 17);
        drain();
        send(1'b1, P3, K_NONE, 0);          // lone tens times out
        expect_timeout(17);
        drain();
        send(1'b1, P3, K_NONE, 0);          // overwrite restarts the timeout
        idle(10);
        send(1'b1, P4, K_NONE, 0);
        expect_timeout(17);
        drain();
        send(1'b0, P1, K_NONE, 0);          // following ones alone: no sec_vld
        expect_timeout(17);
        drain();
        send(1'b1, P0, K_NONE, 0);          // minimum value 00
        send(1'b0, P0, K_VLD, 0);
        drain();
        send(1'b1, P5, K_NONE, 0);
        send(1'b0, P9, K_VLD, 59);
        drain();
        send(1'b1, P2, K_NONE, 0);          // reset mid-frame
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        send(1'b0, P1, K_NONE, 0);
        expect_timeout(0);
        drain();
        send(1'b1, P8, K_NONE, 0);          // 8 tens rejected even with ones 8
        send(1'b0, P8, K_ERR, 0);
        drain();
`ifdef SEC_DECONV_DEGLITCH_EN
        pulse(1'b1, P1, K_NONE, 0);
        pulse(1'b1, P1, K_NONE, 0);
        pulse(1'b0, P7, K_NONE, 0);
        pulse(1'b0, P8, K_NONE, 0);
        pulse(1'b0, P8, K_VLD, 18);
        drain();
`endif
        final_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
